// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_pkg: op codes and FSM state encoding shared by the HI/LO divide controller
package hilo_pkg;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_if: Start/Ready handshake bundle between the controller and the external divider
interface hilo_div_if;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    modport master (output div_start, div_signed, div_a, div_b, div_annul, input div_ready, div_result);
    modport slave (input div_start, div_signed, div_a, div_b, div_annul, output div_ready, div_result);
endinterface

// File: rtl/hilo_div_ctrl_mul.sv
// hilo_mul: combinational 32x32->64 multiplier, signed or unsigned
module hilo_mul (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sgn_i,
    output logic [63:0] p_o
);
    logic signed [63:0] ax, bx;
    assign ax  = {{32{sgn_i & a_i[31]}}, a_i};
    assign bx  = {{32{sgn_i & b_i[31]}}, b_i};
    assign p_o = ax * bx;
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences the shared divider and owns architectural HI/LO for EX
module hilo_div_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    hilo_div_if.master  div
);
    state_e      state_q, state_d;
    logic [CW-1:0] wd_q, wd_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic        start_q, start_d, sgn_q, sgn_d, annul_q, annul_d, err_q, err_d;
    logic [63:0] prod;
    logic        acc, is_div, div_go;
    hilo_mul u_mul (.a_i(req_a), .b_i(req_b), .sgn_i(req_op == OP_MULT), .p_o(prod));
    assign acc     = req_valid & ~flush;
    assign is_div  = (req_op == OP_DIV) | (req_op == OP_DIVU);
    assign div_go  = (state_q == IDLE) & acc & is_div & (req_b != '0);
    assign stall_o = (state_q == BUSY) | div_go;
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        start_d = start_q;
        annul_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_go) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sgn_d   = req_op == OP_DIV;
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = BUSY;
                end else if (acc & ((req_op == OP_MULT) | (req_op == OP_MULTU))) begin
                    {hi_d, lo_d} = prod;
                end else if (acc & (req_op == OP_MTHI)) begin
                    hi_d = req_a;
                end else if (acc & (req_op == OP_MTLO)) begin
                    lo_d = req_a;
                end
            end
            BUSY: begin
                wd_d = wd_q + 1'b1;
                // flush wins over a same-cycle ready so a killed divide never lands in HI/LO
                if (flush) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    state_d = IDLE;
                end else if (div.div_ready) begin
                    {hi_d, lo_d} = div.div_result;
                    start_d      = 1'b0;
                    state_d      = DRAIN;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            start_q <= 1'b0;
            annul_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            start_q <= start_d;
            annul_q <= annul_d;
            err_q   <= err_d;
        end
    end
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign err_o          = err_q;
    assign div.div_start  = start_q;
    assign div.div_signed = sgn_q;
    assign div.div_a      = a_q;
    assign div.div_b      = b_q;
    assign div.div_annul  = annul_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: directed checks of the HI/LO divide controller with a hand-driven divider
module tb_hilo_div_ctrl;
    import hilo_pkg::*;
    logic        clk = 0, rst = 1, req_valid = 0, flush = 0;
    logic [2:0]  req_op = OP_NONE;
    logic [31:0] req_a = 0, req_b = 0, hi_o, lo_o;
    logic        stall_o, err_o;
    int          errors = 0, checks = 0;
    hilo_div_if dif ();
    hilo_div_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o), .div(dif)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
    endtask
    task automatic idle_req();
        req_valid = 0;
        req_op    = OP_NONE;
        #1;
    endtask
    initial begin
        dif.div_ready  = 0;
        dif.div_result = 0;
        step();
        step();
        rst = 0;
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        chk("rst_ctl", {dif.div_start, dif.div_annul, err_o, stall_o, dif.div_signed}, 64'h0);
        chk("rst_ops", {dif.div_a, dif.div_b}, 64'h0);
        // DIV -7 / 2
        req(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_acc_stall", stall_o, 1);
        step();
        idle_req();
        chk("div_start", dif.div_start, 1);
        chk("div_signed", dif.div_signed, 1);
        chk("div_ops", {dif.div_a, dif.div_b}, {32'hFFFF_FFF9, 32'd2});
        chk("div_busy_stall", stall_o, 1);
        step();
        chk("div_start_held", dif.div_start, 1);
        dif.div_ready  = 1;
        dif.div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        #1;
        chk("div_ready_stall", stall_o, 1);
        step();
        dif.div_ready = 0;
        chk("div_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("drain_start", dif.div_start, 0);
        chk("drain_stall", stall_o, 0);
        step();
        // DIVU 0xFFFFFFFF / 0x10 followed by an immediate second DIVU
        req(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        step();
        chk("divu_signed", dif.div_signed, 0);
        req(OP_DIVU, 32'hFFFF_FFFF, 32'h3);
        dif.div_ready  = 1;
        dif.div_result = {32'h0000_000F, 32'h0FFF_FFFF};
        step();
        dif.div_ready = 0;
        #1;
        chk("divu_hilo", {hi_o, lo_o}, {32'h0000_000F, 32'h0FFF_FFFF});
        chk("drain_no_accept_stall", stall_o, 0);
        chk("drain_no_accept_start", dif.div_start, 0);
        step();
        chk("idle_second_start", dif.div_start, 0);
        chk("idle_second_stall", stall_o, 1);
        step();
        idle_req();
        chk("second_start", dif.div_start, 1);
        chk("second_b", dif.div_b, 32'h3);
        dif.div_ready  = 1;
        dif.div_result = {32'h0, 32'h5555_5555};
        step();
        dif.div_ready = 0;
        chk("second_hilo", {hi_o, lo_o}, {32'h0, 32'h5555_5555});
        step();
        // MTHI/MTLO then divide by zero
        req(OP_MTHI, 32'h11, 0);
        step();
        req(OP_MTLO, 32'h22, 0);
        step();
        chk("mthi_mtlo", {hi_o, lo_o}, {32'h11, 32'h22});
        req(OP_DIV, 32'd9, 32'd0);
        chk("div0_stall", stall_o, 0);
        step();
        idle_req();
        chk("div0_start", dif.div_start, 0);
        chk("div0_hilo", {hi_o, lo_o}, {32'h11, 32'h22});
        // flush in IDLE ignores the request
        req(OP_DIV, 32'd9, 32'd3);
        flush = 1;
        #1;
        chk("idle_flush_stall", stall_o, 0);
        step();
        flush = 0;
        idle_req();
        chk("idle_flush_start", dif.div_start, 0);
        // flush on the ready cycle
        req(OP_DIV, 32'd100, 32'd7);
        step();
        idle_req();
        dif.div_ready  = 1;
        dif.div_result = {32'd2, 32'd14};
        flush = 1;
        step();
        dif.div_ready = 0;
        flush = 0;
        #1;
        chk("flush_annul", dif.div_annul, 1);
        chk("flush_start", dif.div_start, 0);
        chk("flush_hilo", {hi_o, lo_o}, {32'h11, 32'h22});
        chk("flush_stall", stall_o, 0);
        step();
        chk("flush_annul_once", dif.div_annul, 0);
        // multiply
        req(OP_MULT, 32'h8000_0000, 32'd2);
        chk("mult_stall", stall_o, 0);
        step();
        chk("mult_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'h0});
        req(OP_MULTU, 32'h8000_0000, 32'd2);
        step();
        chk("multu_hilo", {hi_o, lo_o}, {32'h1, 32'h0});
        req(3'd7, 32'h1234, 32'h5678);
        chk("unk_stall", stall_o, 0);
        step();
        idle_req();
        chk("unk_hilo", {hi_o, lo_o}, {32'h1, 32'h0});
        // watchdog: 15 BUSY cycles without ready
        req(OP_DIV, 32'd5, 32'd1);
        step();
        idle_req();
        for (int i = 0; i < 14; i++) step();
        chk("wd_pre_err", {err_o, stall_o, dif.div_start}, 3'b011);
        step();
        chk("wd_err", {err_o, dif.div_annul, dif.div_start, stall_o}, 4'b1100);
        chk("wd_hilo", {hi_o, lo_o}, {32'h1, 32'h0});
        step();
        chk("wd_err_once", {err_o, dif.div_annul}, 2'b00);
        // reset in the middle of a divide
        req(OP_DIV, 32'd50, 32'd5);
        step();
        idle_req();
        step();
        rst = 1;
        step();
        chk("mid_rst_ctl", {dif.div_start, dif.div_annul, err_o, stall_o, dif.div_signed}, 64'h0);
        chk("mid_rst_hilo", {hi_o, lo_o, dif.div_a, dif.div_b}, 128'h0);
        rst = 0;
        step();
        chk("post_rst_idle", {stall_o, dif.div_start}, 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sequences the shared multi-cycle Goldschmidt divider and owns the architectural HI/LO registers for the EX stage.
- Accepts DIV/DIVU/MULT/MULTU/MTHI/MTLO requests and holds the divider Start handshake until Ready.
- Stalls the pipeline while a divide is in flight and annuls it on a pipeline flush.
- Writes {remainder, quotient} or the 64-bit product into HI/LO.

Parameters:
- TIMEOUT, 15: max cycles in BUSY waiting for div_ready before forced abort.
- CW, 4: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX-stage instruction carries an op for this block
- req_op  in  3  op code (package constants)
- req_a  in  32  rs value (dividend / multiplicand / MTHI, MTLO data)
- req_b  in  32  rt value (divisor / multiplier)
- flush  in  1  pipeline flush (exception/eret); kills current op
- stall_o  out  1  hold IF..EX; combinational
- hi_o  out  32  architectural HI, registered
- lo_o  out  32  architectural LO, registered
- err_o  out  1  one-cycle pulse on watchdog abort
- div_start  out  1  divider Start, level, registered
- div_signed  out  1  divider Signed, registered
- div_a  out  32  divider dividend, registered
- div_b  out  32  divider divisor, registered
- div_annul  out  1  divider Annul, one-cycle pulse, registered
- div_ready  in  1  divider Ready
- div_result  in  64  divider Result {rem[63:32], quot[31:0]}

Behaviour:
- Reset: state=IDLE; hi_o=lo_o=0; div_start=div_annul=err_o=0; div_signed=0; div_a=div_b=0; watchdog=0.
- Reset mid-divide returns to IDLE with div_start=0 in the same edge.
- States: IDLE, BUSY, DRAIN.
- IDLE, req_valid & !flush:
  - DIV/DIVU with req_b!=0: latch operands into div_a/div_b; div_signed=(op==DIV); div_start=1; watchdog=0; go BUSY.
  - DIV/DIVU with req_b==0: HI/LO unchanged; no divider activity; stall_o=0; stay IDLE.
  - MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of req_a×req_b, written at the next edge; no stall.
  - MTHI/MTLO: hi/lo = req_a at the next edge; no stall.
- IDLE, req_valid & flush: request ignored; no state change.
- stall_o = (state==BUSY) | (state==IDLE & req_valid & !flush & op∈{DIV,DIVU} & req_b!=0). It is 0 in DRAIN, so the divide retires without re-issue.
- BUSY:
  - div_start stays 1; watchdog increments each cycle.
  - div_ready=1 & !flush: hi=div_result[63:32], lo=div_result[31:0]; div_start=0; go DRAIN.
  - flush (has priority over a same-cycle div_ready): result discarded; div_start=0; div_annul=1 for one cycle; go IDLE.
  - watchdog==TIMEOUT-1 without ready: div_start=0; div_annul=1; err_o=1 for one cycle; HI/LO unchanged; go IDLE.
- DRAIN:
  - Exactly one cycle with div_start=0, letting the divider clear Ready on its negative-edge path.
  - req_valid in DRAIN is not accepted (it is the retiring divide). Go IDLE.
- Back-to-back divides: next accept at the earliest in IDLE, one cycle after DRAIN.
- Operands stay frozen in div_a/div_b/div_signed while BUSY.
- MTHI/MTLO/MULT are never seen in BUSY, because the pipeline is stalled.
- Unknown op codes: ignored, no stall.
- Divide latency: accept edge to HI/LO update = divider latency + 1 cycle; stall spans accept cycle through the ready cycle inclusive.

Decomposition:
- Shared package hilo_pkg holds:
  - OP_NONE=0, OP_DIV=1, OP_DIVU=2, OP_MULT=3, OP_MULTU=4, OP_MTHI=5, OP_MTLO=6
  - State encodings IDLE=0, BUSY=1, DRAIN=2
- One natural sub-module: hilo_mul, a combinational signed/unsigned 32×32→64 multiplier so the product path can be retimed separately.
- The divider itself stays external, connected at the top.

Test Plan:
- DIV req_a=-7, req_b=2 → div_start high until ready, div_signed=1; then hi_o=0xFFFFFFFF (-1), lo_o=0xFFFFFFFD (-3); stall_o drops in the DRAIN cycle.
- DIVU 0xFFFFFFFF / 0x10 → lo_o=0x0FFFFFFF, hi_o=0xF; a second DIVU issued immediately after is accepted only after DRAIN→IDLE.
- DIV with req_b=0, hi/lo preloaded via MTHI 0x11 / MTLO 0x22 → no stall, div_start stays 0, hi_o=0x11, lo_o=0x22.
- Flush asserted on the same cycle as div_ready → div_annul pulses once, HI/LO unchanged, state IDLE next cycle.
- MULT 0x80000000 × 2 → hi_o=0xFFFFFFFF, lo_o=0x00000000; MULTU same operands → hi_o=0x1, lo_o=0.
- Divider model never asserting ready → after TIMEOUT cycles err_o and div_annul pulse, stall_o releases; rst asserted mid-BUSY → all outputs at reset values next edge.
